decodificador_teclado: RTL

Upstream stage of the lock's operational FSM. It scans a 4x4 matrix keypad, synchronises and debounces the column lines, and emits one key_valid pulse with a 4-bit key_code per debounced press. It directly drives the key_valid/key_code inputs of the PIN-assembly logic in operacional, and runs on the same 1 kHz system clock.

---
 rtl/decodificador_teclado_pkg.sv | 63 ++++++
 rtl/decodificador_teclado_sincronizador.sv | 26 ++
 rtl/decodificador_teclado.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/decodificador_teclado_pkg.sv
// Shared types and constants for the keypad front end and the lock's PIN logic.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package decodificador_teclado_pkg;

    // Four-digit PIN as assembled by operacional.
    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } pinPac_t;

    // Two-digit BCD value used by the display path.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcdPac_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        VALID,
        WAIT_RELEASE
    } kbd_state_t;

    // Indexed [row][col], row 0 is the top row of the keypad.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1,     4'h2, 4'h3,     KEY_A},
        '{4'h4,     4'h5, 4'h6,     KEY_B},
        '{4'h7,     4'h8, 4'h9,     KEY_C},
        '{KEY_STAR, 4'h0, KEY_HASH, KEY_D}
    };

    // Result of inspecting the active-low column lines of one row.
    typedef struct packed {
        logic       single;  // exactly one column is low
        logic [1:0] idx;     // index of the low column when single is set
    } col_hit_t;

    function automatic col_hit_t decode_cols(input logic [3:0] cols);
        col_hit_t hit;
        int       zeros;
        hit   = '0;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!cols[i]) begin
                zeros++;
                hit.idx = 2'(i);
            end
        end
        hit.single = (zeros == 1);
        return hit;
    endfunction

endpackage

// File: rtl/decodificador_teclado_sincronizador.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all ones (idle keypad).
// Latency: 2 clk cycles.
// Backpressure: none, free-running sampler.
module decodificador_teclado_sincronizador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/decodificador_teclado.sv
// 4x4 keypad scanner: drives rows one-hot-low, debounces columns, emits one key_valid pulse per press.
// Latency: key_valid 1+DEBOUNCE_CYCLES cycles after the scan sample that first sees the key.
// Backpressure: none; key_valid is a single-cycle pulse, key_code holds until the next press.
module decodificador_teclado
    import decodificador_teclado_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_matrix,
    output logic [3:0] lin_matrix,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Counters stop at their top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_TOP) ? v : v + CNT_W'(1);
    endfunction

    kbd_state_t       state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic             key_valid_d;
    logic [3:0]       key_code_d;

    logic [3:0] col_s;
    logic [3:0] col_expected;
    col_hit_t   hit;

    decodificador_teclado_sincronizador #(
        .WIDTH (4)
    ) u_sincronizador (
        .clk (clk),
        .rst (rst),
        .d   (col_matrix),
        .q   (col_s)
    );

    assign lin_matrix   = ~(4'b0001 << row_q);
    assign col_expected = ~(4'b0001 << col_q);
    assign hit          = decode_cols(col_s);

    // State, scan position, counters and the registered key outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SCAN;
            row_q     <= '0;
            col_q     <= '0;
            settle_q  <= '0;
            deb_q     <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            settle_q  <= settle_d;
            deb_q     <= deb_d;
            key_valid <= key_valid_d;
            key_code  <= key_code_d;
        end
    end

    // Next-state logic: scan rows, qualify a single low column, debounce press and release.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        settle_d    = settle_q;
        deb_d       = deb_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code;

        case (state_q)
            SCAN: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    if (hit.single) begin
                        col_d   = hit.idx;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        // Idle row or ghosting (several lows): move on.
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    settle_d = sat_inc(settle_q);
                end
            end

            DEBOUNCE: begin
                if (col_s == col_expected) begin
                    if (deb_q == DEB_LAST) begin
                        state_d     = VALID;
                        key_valid_d = 1'b1;
                        key_code_d  = KEY_MAP[row_q][col_q];
                    end else begin
                        deb_d = sat_inc(deb_q);
                    end
                end else begin
                    // Bounce or glitch: rescan the same row from scratch.
                    state_d  = SCAN;
                    settle_d = '0;
                end
            end

            VALID: begin
                state_d = WAIT_RELEASE;
                deb_d   = '0;
            end

            WAIT_RELEASE: begin
                if (&col_s) begin
                    if (deb_q == DEB_LAST) begin
                        state_d  = SCAN;
                        row_d    = row_q + 2'd1;
                        settle_d = '0;
                    end else begin
                        deb_d = sat_inc(deb_q);
                    end
                end else begin
                    deb_d = '0;
                end
            end

            default: begin
                state_d  = SCAN;
                settle_d = '0;
            end
        endcase
    end

endmodule
